// File: rtl/planet_snd_sched_if.sv
// Request/status bundle between the Planet Empire event logic and the sound scheduler.
// The game side uses the master modport; the scheduler uses the slave modport.
interface planet_snd_sched_if;
  logic       EE_i;
  logic [2:0] REQs_i;
  logic       MUTE_i;
  logic       SOUND_o;
  logic       BUSY_o;
  logic [2:0] ACT_IDs_o;
  logic [2:0] ACKs_o;
  logic [2:0] DONEs_o;

  modport master (
    output EE_i, REQs_i, MUTE_i,
    input  SOUND_o, BUSY_o, ACT_IDs_o, ACKs_o, DONEs_o
  );

  modport slave (
    input  EE_i, REQs_i, MUTE_i,
    output SOUND_o, BUSY_o, ACT_IDs_o, ACKs_o, DONEs_o
  );
endinterface

// File: rtl/planet_snd_sched.sv
// Three-requester priority tone scheduler driving the single piezo output.
// Index 0 has the highest priority; a higher-priority request preempts the tone in progress.
module planet_snd_sched #(
  parameter int C_HALF0 = 150,
  parameter int C_HALF1 = 300,
  parameter int C_HALF2 = 600,
  parameter int C_DUR0  = 100_000,
  parameter int C_DUR1  = 50_000,
  parameter int C_DUR2  = 500_000,
  parameter int C_GAP_N = 20_000
) (
  input  logic                 CK_i,
  input  logic                 XARST_i,
  planet_snd_sched_if.slave    bus
);

  function automatic int cnt_w(input int max_val);
    int w;
    w = 1;
    while ((1 << w) < max_val) w++;
    return w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Isolates the lowest set bit, i.e. the highest-priority requester.
  function automatic logic [2:0] lowest_one(input logic [2:0] v);
    return v & (~v + 3'd1);
  endfunction

  localparam int HALF_W = cnt_w(max3(C_HALF0, C_HALF1, C_HALF2));
  localparam int DUR_W  = cnt_w(max3(C_DUR0, C_DUR1, C_DUR2));
  localparam int GAP_W  = cnt_w((C_GAP_N > 1) ? C_GAP_N : 1);

  localparam logic [HALF_W-1:0] HALF0_LIM = HALF_W'(C_HALF0 - 1);
  localparam logic [HALF_W-1:0] HALF1_LIM = HALF_W'(C_HALF1 - 1);
  localparam logic [HALF_W-1:0] HALF2_LIM = HALF_W'(C_HALF2 - 1);
  localparam logic [DUR_W-1:0]  DUR0_LIM  = DUR_W'(C_DUR0 - 1);
  localparam logic [DUR_W-1:0]  DUR1_LIM  = DUR_W'(C_DUR1 - 1);
  localparam logic [DUR_W-1:0]  DUR2_LIM  = DUR_W'(C_DUR2 - 1);
  localparam logic [GAP_W-1:0]  GAP_LIM   = GAP_W'((C_GAP_N > 0) ? C_GAP_N - 1 : 0);
  localparam bit                HAS_GAP   = (C_GAP_N > 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [2:0]         pend;
  logic [2:0]         act_oh;
  logic [HALF_W-1:0]  half_cnt;
  logic [DUR_W-1:0]   dur_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               snd;
  logic               busy;
  logic [2:0]         ack;
  logic [2:0]         done;

  logic [2:0]         req_all;
  logic [2:0]         grant_oh;
  logic [2:0]         grant_mask;
  logic [2:0]         abort_mask;
  logic [2:0]         hold_mask;
  logic [2:0]         pend_nxt;
  logic [HALF_W-1:0]  half_lim;
  logic [DUR_W-1:0]   dur_lim;
  logic               in_play;
  logic               completion;
  logic               preempt;
  logic               retrig;
  logic               gap_end;
  logic               do_grant;

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Completion is only possible in PLAY and preemption requires a non-completion
  // clock, so ACK and DONE can never coincide.
  always_comb begin
    req_all    = pend | bus.REQs_i;
    grant_oh   = lowest_one(req_all);
    half_lim   = act_oh[0] ? HALF0_LIM : (act_oh[1] ? HALF1_LIM : HALF2_LIM);
    dur_lim    = act_oh[0] ? DUR0_LIM  : (act_oh[1] ? DUR1_LIM  : DUR2_LIM);
    in_play    = (state == S_PLAY);
    completion = in_play && bus.EE_i && (dur_cnt == dur_lim);
    preempt    = in_play && !completion && (|(req_all & (act_oh - 3'd1)));
    retrig     = in_play && !completion && !preempt && (|(bus.REQs_i & act_oh));
    gap_end    = (state == S_GAP) && bus.EE_i && (gap_cnt == GAP_LIM);
    do_grant   = (|req_all) && ((state == S_IDLE) || gap_end || preempt);
    grant_mask = do_grant ? grant_oh : 3'b000;
    abort_mask = preempt ? act_oh : 3'b000;
    // The active tone never re-queues itself; its own request is a retrigger.
    hold_mask  = (in_play && !completion) ? act_oh : 3'b000;
    pend_nxt   = req_all & ~(grant_mask | abort_mask | hold_mask);

    state_nxt = state;
    case (state)
      S_IDLE: if (do_grant) state_nxt = S_PLAY;
      S_PLAY: if (completion) state_nxt = HAS_GAP ? S_GAP : S_IDLE;
      S_GAP:  if (gap_end) state_nxt = do_grant ? S_PLAY : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      pend     <= 3'b000;
      act_oh   <= 3'b000;
      half_cnt <= '0;
      dur_cnt  <= '0;
      gap_cnt  <= '0;
      snd      <= 1'b0;
      busy     <= 1'b0;
      ack      <= 3'b000;
      done     <= 3'b000;
    end else begin
      pend <= pend_nxt;
      ack  <= grant_mask;
      done <= completion ? act_oh : 3'b000;
      busy <= (state_nxt != S_IDLE);

      if (do_grant) begin
        act_oh   <= grant_oh;
        half_cnt <= '0;
        dur_cnt  <= '0;
        snd      <= 1'b0;
      end else if (completion) begin
        act_oh   <= 3'b000;
        half_cnt <= '0;
        dur_cnt  <= '0;
        snd      <= 1'b0;
      end else if (in_play) begin
        if (bus.EE_i) begin
          if (half_cnt == half_lim) begin
            half_cnt <= '0;
            snd      <= ~snd;
          end else begin
            half_cnt <= half_cnt + HALF_W'(1);
          end
        end
        // A retrigger restarts the duration but leaves the tone phase alone.
        if (retrig)         dur_cnt <= '0;
        else if (bus.EE_i)  dur_cnt <= dur_cnt + DUR_W'(1);
      end

      if (state != S_GAP)   gap_cnt <= '0;
      else if (gap_end)     gap_cnt <= '0;
      else if (bus.EE_i)    gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

  assign bus.SOUND_o   = snd & ~bus.MUTE_i;
  assign bus.BUSY_o    = busy;
  assign bus.ACT_IDs_o = act_oh;
  assign bus.ACKs_o    = ack;
  assign bus.DONEs_o   = done;

endmodule

// File: tb/tb_planet_snd_sched.sv
// Bench for planet_snd_sched: table of single-tone runs plus hand-written priority sequences,
// with ACK/DONE pulses matched against an event scoreboard by cycle number.
module tb_planet_snd_sched;
  localparam int H0 = 2, H1 = 3, H2 = 5;
  localparam int D0 = 20, D1 = 30, D2 = 40;
  localparam int GAP = 4;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_fail;

  typedef struct {
    bit         is_done;
    logic [2:0] id;
    int         at;
  } ev_t;

  typedef struct {
    logic [2:0] reqs;
    logic       mute;
    int         half;
    int         dur;
    logic [2:0] exp_act;
  } row_t;

  ev_t  exp_q[$];
  row_t rows[4];

  planet_snd_sched_if sif();

  planet_snd_sched #(
    .C_HALF0(H0), .C_HALF1(H1), .C_HALF2(H2),
    .C_DUR0(D0),  .C_DUR1(D1),  .C_DUR2(D2),
    .C_GAP_N(GAP)
  ) dut (
    .CK_i   (clk),
    .XARST_i(rst_n),
    .bus    (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input bit d, input logic [2:0] id, input int at);
    ev_t e;
    e.is_done = d;
    e.id      = id;
    e.at      = at;
    exp_q.push_back(e);
  endtask

  task automatic match_ev(input bit d, input logic [2:0] id);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event at cycle %0d: got %s %b, expected none", cyc, d ? "DONE" : "ACK", id);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done !== d || e.id !== id || e.at != cyc) begin
        n_fail++;
        $display("FAIL event_order: got %s %b at cycle %0d, expected %s %b at cycle %0d",
                 d ? "DONE" : "ACK", id, cyc, e.is_done ? "DONE" : "ACK", e.id, e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sif.ACKs_o != 3'b000)  match_ev(1'b0, sif.ACKs_o);
      if (sif.DONEs_o != 3'b000) match_ev(1'b1, sif.DONEs_o);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_sound"}, 32'(sif.SOUND_o),   32'd0);
    chk({tag, "_busy"},  32'(sif.BUSY_o),    32'd0);
    chk({tag, "_act"},   32'(sif.ACT_IDs_o), 32'd0);
    chk({tag, "_ack"},   32'(sif.ACKs_o),    32'd0);
    chk({tag, "_done"},  32'(sif.DONEs_o),   32'd0);
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_missing_events"}, 32'(exp_q.size()), 32'd0);
  endtask

  // One isolated tone: waveform every play clock, then the silent gap, then idle.
  task automatic run_row(input row_t r);
    int c;
    logic exp_snd;
    c = cyc;
    sif.REQs_i = r.reqs;
    sif.MUTE_i = r.mute;
    push_ev(1'b0, r.exp_act, c + 1);
    push_ev(1'b1, r.exp_act, c + 1 + r.dur);
    step();
    sif.REQs_i = 3'b000;
    for (int n = 0; n < r.dur; n++) begin
      exp_snd = r.mute ? 1'b0 : (((n / r.half) % 2) == 1);
      chk("row_busy",  32'(sif.BUSY_o),    32'd1);
      chk("row_act",   32'(sif.ACT_IDs_o), 32'(r.exp_act));
      chk("row_sound", 32'(sif.SOUND_o),   32'(exp_snd));
      step();
    end
    chk("row_end_act",   32'(sif.ACT_IDs_o), 32'd0);
    chk("row_end_sound", 32'(sif.SOUND_o),   32'd0);
    for (int g = 0; g < GAP; g++) begin
      chk("row_gap_busy",  32'(sif.BUSY_o),  32'd1);
      chk("row_gap_sound", 32'(sif.SOUND_o), 32'd0);
      step();
    end
    chk("row_idle_busy", 32'(sif.BUSY_o), 32'd0);
    sif.MUTE_i = 1'b0;
    chk_drained("row");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int g0;

    rows[0] = '{3'b001, 1'b0, H0, D0, 3'b001};
    rows[1] = '{3'b010, 1'b0, H1, D1, 3'b010};
    rows[2] = '{3'b100, 1'b0, H2, D2, 3'b100};
    rows[3] = '{3'b100, 1'b1, H2, D2, 3'b100};

    n_chk      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    sif.EE_i   = 1'b1;
    sif.REQs_i = 3'b000;
    sif.MUTE_i = 1'b0;

    // Reset held, then released with no requests.
    steps(3);
    chk_quiet("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_quiet("idle");
    end

    for (int i = 0; i < 4; i++) begin
      run_row(rows[i]);
      steps(2);
    end

    // Tone 2 preempted by tone 0 at play clock 10; tone 2 is dropped.
    c = cyc;
    sif.REQs_i = 3'b100;
    push_ev(1'b0, 3'b100, c + 1);
    step();
    sif.REQs_i = 3'b000;
    g0 = cyc;
    steps(9);
    sif.REQs_i = 3'b001;
    push_ev(1'b0, 3'b001, g0 + 10);
    push_ev(1'b1, 3'b001, g0 + 10 + D0);
    step();
    sif.REQs_i = 3'b000;
    chk("preempt_act",   32'(sif.ACT_IDs_o), 32'b001);
    chk("preempt_sound", 32'(sif.SOUND_o),   32'd0);
    chk("preempt_busy",  32'(sif.BUSY_o),    32'd1);
    steps(D0);
    chk("preempt_done_act", 32'(sif.ACT_IDs_o), 32'd0);
    steps(GAP);
    chk("preempt_idle", 32'(sif.BUSY_o), 32'd0);
    steps(50);
    chk("preempt_no_replay_busy", 32'(sif.BUSY_o), 32'd0);
    chk_drained("preempt");

    // Tone 0 playing while 1 and 2 arrive together: served in order 0, 1, 2.
    c = cyc;
    sif.REQs_i = 3'b001;
    push_ev(1'b0, 3'b001, c + 1);
    push_ev(1'b1, 3'b001, c + 1 + D0);
    step();
    sif.REQs_i = 3'b000;
    g0 = cyc;
    steps(4);
    sif.REQs_i = 3'b110;
    push_ev(1'b0, 3'b010, g0 + D0 + GAP);
    push_ev(1'b1, 3'b010, g0 + D0 + GAP + D1);
    push_ev(1'b0, 3'b100, g0 + D0 + GAP + D1 + GAP);
    push_ev(1'b1, 3'b100, g0 + D0 + GAP + D1 + GAP + D2);
    step();
    sif.REQs_i = 3'b000;
    steps(D0 + GAP - 5);
    chk("queue_second_act", 32'(sif.ACT_IDs_o), 32'b010);
    steps(D1 + GAP);
    chk("queue_third_act", 32'(sif.ACT_IDs_o), 32'b100);
    steps(D2 + GAP);
    chk("queue_idle", 32'(sif.BUSY_o), 32'd0);
    chk_drained("queue");

    // Retrigger of tone 1 at play clock 25 moves DONE to clock 55 without a new ACK.
    c = cyc;
    sif.REQs_i = 3'b010;
    push_ev(1'b0, 3'b010, c + 1);
    push_ev(1'b1, 3'b010, c + 1 + 55);
    step();
    sif.REQs_i = 3'b000;
    g0 = cyc;
    steps(24);
    sif.REQs_i = 3'b010;
    step();
    sif.REQs_i = 3'b000;
    steps(29);
    chk("retrig_still_playing", 32'(sif.ACT_IDs_o), 32'b010);
    step();
    chk("retrig_done_act", 32'(sif.ACT_IDs_o), 32'd0);
    chk("retrig_clock", 32'(cyc - g0), 32'd55);
    steps(GAP);
    chk("retrig_idle", 32'(sif.BUSY_o), 32'd0);
    chk_drained("retrig");

    // Request landing on tone 1's completion clock waits for the gap.
    c = cyc;
    sif.REQs_i = 3'b010;
    push_ev(1'b0, 3'b010, c + 1);
    push_ev(1'b1, 3'b010, c + 1 + D1);
    step();
    sif.REQs_i = 3'b000;
    g0 = cyc;
    steps(D1 - 1);
    sif.REQs_i = 3'b001;
    push_ev(1'b0, 3'b001, g0 + D1 + GAP);
    push_ev(1'b1, 3'b001, g0 + D1 + GAP + D0);
    step();
    sif.REQs_i = 3'b000;
    chk("late_req_gap_act",  32'(sif.ACT_IDs_o), 32'd0);
    chk("late_req_gap_busy", 32'(sif.BUSY_o),    32'd1);
    steps(GAP);
    chk("late_req_grant_act", 32'(sif.ACT_IDs_o), 32'b001);
    steps(D0);
    chk("late_req_done_act", 32'(sif.ACT_IDs_o), 32'd0);
    steps(GAP);
    chk("late_req_idle", 32'(sif.BUSY_o), 32'd0);
    chk_drained("late_req");

    // Asynchronous reset while the tone output is high.
    c = cyc;
    sif.REQs_i = 3'b001;
    push_ev(1'b0, 3'b001, c + 1);
    step();
    sif.REQs_i = 3'b000;
    steps(H0);
    chk("pre_reset_sound", 32'(sif.SOUND_o), 32'd1);
    chk_drained("pre_reset");
    rst_n = 1'b0;
    #1;
    chk("async_reset_sound", 32'(sif.SOUND_o),   32'd0);
    chk("async_reset_busy",  32'(sif.BUSY_o),    32'd0);
    chk("async_reset_act",   32'(sif.ACT_IDs_o), 32'd0);
    steps(2);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_quiet("post_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
